// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared constants for the serial detector FSM family
//
// Purpose: match-mode constants and parameter legality limits shared by the
// pattern detectors and their status blocks.
// Ports: none (package).
package fsm_pkg;

    // Match modes for the OVERLAP parameter.
    localparam int MODE_NON_OVERLAP = 0;
    localparam int MODE_OVERLAP     = 1;

    // Legal pattern lengths.
    localparam int LEN_MIN = 2;
    localparam int LEN_MAX = 32;

    // Legal match counter widths.
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose: counts inc pulses, stopping at all-ones. A clear on the same edge
// as an increment leaves the count at 1, so the coincident event is kept.
// Ports:
//   clk    in  1  clock
//   reset  in  1  synchronous, active-high
//   clr    in  1  synchronous clear
//   inc    in  1  count one event
//   q      out W  current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector
//
// Purpose: watches an en-qualified serial bit stream for a LEN-bit PATTERN
// (MSB received first), in overlapping or non-overlapping mode. Produces a
// registered match pulse, a sticky seen flag and a saturating match count.
// Ports:
//   clk        in  1      clock
//   reset      in  1      synchronous, active-high; wins over en and clear
//   en         in  1      a bit is consumed only when en=1
//   a          in  1      serial data bit
//   clear      in  1      synchronous clear of seen and match_cnt
//   match      out 1      one-cycle pulse per detected pattern
//   seen       out 1      sticky match flag
//   match_cnt  out CNT_W  saturating match count
module seq_detect_param
    import fsm_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = MODE_OVERLAP,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic             clear,
    output logic             match,
    output logic             seen,
    output logic [CNT_W-1:0] match_cnt
);

    if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
        $error("seq_detect_param: LEN out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W out of range");
    end

    localparam int             FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [LEN-1:0]    hist;
    logic [LEN-1:0]    hist_n;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

    // fill gates detection so bits left over from before reset or before a
    // non-overlapping match can never complete a pattern.
    always_comb begin
        hist_n = hist;
        fill_n = fill;
        hit    = 1'b0;
        if (en) begin
            hist_n = {hist[LEN-2:0], a};
            fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
            hit    = (fill_n == FILL_FULL) && (hist_n == PATTERN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            hist  <= hist_n;
            fill  <= (hit && (OVERLAP == MODE_NON_OVERLAP)) ? '0 : fill_n;
            match <= hit;
        end
    end

    // A hit on the clearing edge still leaves seen set.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen <= 1'b0;
        end else if (hit) begin
            seen <= 1'b1;
        end else if (clear) begin
            seen <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clear),
        .inc  (hit),
        .q    (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] en;
    logic [2:0] a;
    logic [2:0] clr;
    logic [2:0] m;
    logic [2:0] sn;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // DUT0: overlapping 1011, DUT1: non-overlapping 1011, DUT2: 11 with 2-bit count
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_ovl (
        .clk(clk), .reset(reset), .en(en[0]), .a(a[0]), .clear(clr[0]),
        .match(m[0]), .seen(sn[0]), .match_cnt(cnt0));

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_novl (
        .clk(clk), .reset(reset), .en(en[1]), .a(a[1]), .clear(clr[1]),
        .match(m[1]), .seen(sn[1]), .match_cnt(cnt1));

    seq_detect_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en[2]), .a(a[2]), .clear(clr[2]),
        .match(m[2]), .seen(sn[2]), .match_cnt(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input int d, input logic b, input logic c);
        en[d]  = 1'b1;
        a[d]   = b;
        clr[d] = c;
        @(posedge clk);
        #1;
        en[d]  = 1'b0;
        a[d]   = 1'b0;
        clr[d] = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m"}, {29'd0, m}, 32'd0);
        chk({tag, "_seen"}, {29'd0, sn}, 32'd0);
        chk({tag, "_cnt0"}, {24'd0, cnt0}, 32'd0);
        chk({tag, "_cnt1"}, {24'd0, cnt1}, 32'd0);
        chk({tag, "_cnt2"}, {30'd0, cnt2}, 32'd0);
    endtask

    initial begin
        logic [6:0] s7;
        logic [6:0] e7;
        logic [3:0] s4;
        logic [3:0] e4;
        logic [5:0] e6;
        logic [1:0] c6 [6];

        en = '0; a = '0; clr = '0; reset = 1'b1;
        idle(); idle();
        reset = 1'b0;
        chk_all_zero("reset");

        // Overlap: 1,0,1,1,0,1,1 -> hits after bits 4 and 7
        s7 = 7'b1011011;
        e7 = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            send(0, s7[6-i], 1'b0);
            chk($sformatf("ovl_match_b%0d", i + 1), {31'd0, m[0]}, {31'd0, e7[6-i]});
        end
        chk("ovl_cnt", {24'd0, cnt0}, 32'd2);
        chk("ovl_seen", {31'd0, sn[0]}, 32'd1);

        // Non-overlap: same stream -> only the hit after bit 4
        e7 = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            send(1, s7[6-i], 1'b0);
            chk($sformatf("novl_match_b%0d", i + 1), {31'd0, m[1]}, {31'd0, e7[6-i]});
        end
        chk("novl_cnt1", {24'd0, cnt1}, 32'd1);
        s4 = 4'b1011;
        e4 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            send(1, s4[3-i], 1'b0);
            chk($sformatf("novl2_match_b%0d", i + 1), {31'd0, m[1]}, {31'd0, e4[3-i]});
        end
        chk("novl_cnt2", {24'd0, cnt1}, 32'd2);

        // Clear alone, then 1,0,1,1 with 3-cycle en gaps
        clr[0] = 1'b1;
        idle();
        clr[0] = 1'b0;
        chk("clr_seen", {31'd0, sn[0]}, 32'd0);
        chk("clr_cnt", {24'd0, cnt0}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(0, s4[3-i], 1'b0);
            chk($sformatf("gap_match_b%0d", i + 1), {31'd0, m[0]}, {31'd0, e4[3-i]});
            for (int g = 0; g < 3; g++) begin
                idle();
                chk($sformatf("gap_idle_b%0d_%0d", i + 1, g), {31'd0, m[0]}, 32'd0);
            end
        end
        chk("gap_cnt", {24'd0, cnt0}, 32'd1);

        // Reset after partial prefix 1,0,1
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk_all_zero("midrst");
        send(0, 1'b1, 1'b0);
        chk("midrst_no_match", {31'd0, m[0]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(0, s4[3-i], 1'b0);
            chk($sformatf("midrst_match_b%0d", i + 1), {31'd0, m[0]}, {31'd0, e4[3-i]});
        end
        chk("midrst_cnt", {24'd0, cnt0}, 32'd1);

        // Build count to 5, then clear collides with a hit
        for (int r = 0; r < 4; r++) begin
            send(0, 1'b0, 1'b0);
            send(0, 1'b1, 1'b0);
            send(0, 1'b1, 1'b0);
        end
        chk("pre_clr_cnt", {24'd0, cnt0}, 32'd5);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0);
        send(0, 1'b1, 1'b1);
        chk("clrhit_match", {31'd0, m[0]}, 32'd1);
        chk("clrhit_cnt", {24'd0, cnt0}, 32'd1);
        chk("clrhit_seen", {31'd0, sn[0]}, 32'd1);

        // Saturation: six ones into LEN=2 all-ones, CNT_W=2
        e6 = 6'b011111;
        c6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            send(2, 1'b1, 1'b0);
            chk($sformatf("sat_match_b%0d", i + 1), {31'd0, m[2]}, {31'd0, e6[5-i]});
            chk($sformatf("sat_cnt_b%0d", i + 1), {30'd0, cnt2}, {30'd0, c6[i]});
        end
        chk("sat_seen", {31'd0, sn[2]}, 32'd1);
        idle();
        chk("sat_match_drop", {31'd0, m[2]}, 32'd0);
        chk("sat_cnt_hold", {30'd0, cnt2}, 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector for single-bit input streams. It generalises the team's fixed three-state detector FSMs to any pattern length and any pattern value, with both overlapping and non-overlapping match modes. It adds a qualifying enable, a sticky flag and a saturating match counter. It sits directly behind a serial input synchroniser and feeds status/interrupt logic.

## Interface
- LEN, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011: LEN-bit target; MSB is the first bit received.
- OVERLAP, 1: 1 allows matches to share bits; 0 restarts the search after each match.
- CNT_W, 8: match counter width; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  qualifies a; a bit is consumed only on an edge where en=1.
- a  in  1  serial data bit.
- clear  in  1  synchronous clear of seen and match_cnt.
- match  out  1  registered one-cycle pulse per detected pattern.
- seen  out  1  sticky: set by any match, cleared by clear or reset.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- State:
  - hist[LEN-1:0]: last LEN accepted bits, newest in bit 0.
  - fill: number of valid bits in hist, range 0..LEN, saturating at LEN.
- On an edge with en=1:
  - hist_n = {hist[LEN-2:0], a}.
  - fill_n = min(fill+1, LEN).
  - hit = (fill_n == LEN) && (hist_n == PATTERN).
- On an edge with en=0: hist and fill hold; hit = 0.
- Register updates:
  - hist <= hist_n.
  - fill <= (hit && !OVERLAP) ? 0 : fill_n.
  - match <= hit.
- seen:
  - clear=1, hit=0: seen <= 0.
  - hit=1: seen <= 1, regardless of clear.
- match_cnt:
  - clear=1: match_cnt <= hit ? 1 : 0.
  - clear=0 and hit=1: match_cnt <= match_cnt + 1, saturating at all-ones. It never wraps.
- hist content beyond fill is don't-care; fill gates detection, so stale bits never cause a match.
- Non-overlap mode: after a match, the next match needs LEN fresh bits.
- Reset values: hist=0, fill=0, match=0, seen=0, match_cnt=0.
- Reset mid-stream: any partial prefix is discarded and the next match needs LEN new bits. reset has priority over en and clear.

## Timing
- Latency: match, seen and match_cnt reflect a hit in the cycle following the edge that accepted the final pattern bit.
- match is high for exactly one cycle per hit. Back-to-back hits on consecutive en edges give a continuous high; this is possible in overlap mode when PATTERN allows it, e.g. all-ones.
- en gaps of any length are transparent; bits need not be on consecutive cycles.
- clear takes effect on the same edge it is sampled; a simultaneous hit is counted after the clear.
- There are no combinational paths from inputs to outputs.

## Structure
- fsm_pkg (shared) holds the mode constants MODE_OVERLAP=1 and MODE_NON_OVERLAP=0, and the LEN/CNT_W legality limits checked by elaboration assertions.
- One sub-module, sat_counter, with parameter W and ports clk, reset, clr, inc, q. It handles the clear-plus-increment priority; it is reusable by other status blocks.
- Detection logic and the fill tracking stay in the top module.

## Test plan
- Overlap: LEN=4, PATTERN=1011, OVERLAP=1, bits 1,0,1,1,0,1,1 with en=1 every cycle -> match pulses after bits 4 and 7; match_cnt=2; seen=1.
- Non-overlap: same stream with OVERLAP=0 -> a single match after bit 4; match_cnt=1; a following 1,0,1,1 gives a match after its 4th bit, match_cnt=2.
- Enable gaps: 1,0,1,1 delivered with en low for 3 cycles between each bit -> one match, in the cycle after the 4th en-qualified edge; no match while en is low.
- Reset mid-stream: after 1,0,1 assert reset for one cycle, then send 1 -> no match; the next 1,0,1,1 matches; all outputs read 0 in the cycle after reset.
- Clear and hit collide: clear asserted on the edge accepting the final bit while match_cnt=5 -> match_cnt=1, seen=1, match pulses.
- Saturation: CNT_W=2, all-ones pattern LEN=2 with OVERLAP=1, 6 ones -> 5 consecutive match cycles; match_cnt stops at 3 and does not wrap.
